tt_um_emern_poly_loader: RTL
============================

TT_UM_EMERN_POLY_LOADER -- requirements
Module: tt_um_emern_poly_loader

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all logic rising-edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port in_data, input, 8 bits: command/data byte stream.
REQ-004 SHALL have port in_valid, input, 1 bit: in_data is valid this cycle.
REQ-005 SHALL have port in_ready, output, 1 bit: loader accepts a byte this cycle.
REQ-006 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of each frame (pixel 0,0).
REQ-007 SHALL have port cmp_en, output, 2 bits: active polygon enables, bit0 = A, bit1 = B.
REQ-008 SHALL have port background_color, output, 6 bits: active background, rrggbb.
REQ-009 SHALL have port poly_color, output, 12 bits: {B[5:0], A[5:0]}.
REQ-010 SHALL have ports v0_x, v1_x, v2_x, output, 14 bits each: {B[6:0], A[6:0]}.
REQ-011 SHALL have ports v0_y, v1_y, v2_y, output, 12 bits each: {B[5:0], A[5:0]}.
REQ-012 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-013 SHALL transfer a byte only on a cycle where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-014 SHALL decode the command byte: [7:6]=00 NOP; 01 LOAD_POLY, [0] selects polygon (0=A, 1=B); 10 SET_BG; 11 SET_EN, [1:0] = new enables.
REQ-015 SHALL implement FSM states IDLE, DATA, XFER; reset state IDLE.
REQ-016 IDLE: NOP and SET_EN complete in the accept cycle with no state change; LOAD_POLY goes to DATA with byte count 7; SET_BG goes to DATA with byte count 1.
REQ-017 DATA: each accepted byte is written to an 7x8-bit staging buffer at index 0..6, with the counter decrementing; after the last byte the FSM goes to XFER.
REQ-018 LOAD_POLY data order SHALL be color, v0_x, v0_y, v1_x, v1_y, v2_x, v2_y; x fields use bits [6:0], y and color fields use bits [5:0], and upper bits are ignored.
REQ-019 XFER lasts exactly one cycle with in_ready=0, copies staging into the selected shadow set (polygon A, polygon B, or background), then returns to IDLE.
REQ-020 SET_EN SHALL write the shadow enables in the accept cycle.
REQ-021 in_ready SHALL be 1 in IDLE and DATA, and 0 in XFER and while rst is high.
REQ-022 On a frame_start cycle, all shadow registers SHALL be copied to the active outputs at the next edge, so outputs change only at frame boundaries.
REQ-023 Shadow writes and the frame_start copy in the same cycle: the active outputs receive the pre-write shadow, and the new shadow value goes live at the next frame_start.
REQ-024 A partially received LOAD_POLY or SET_BG SHALL never modify the shadow registers; only XFER commits.
REQ-025 frame_start SHALL NOT stall or alter the FSM; a multi-byte command may span frame boundaries.
REQ-026 Loading a polygon SHALL NOT change cmp_en; enables change only via SET_EN.
REQ-027 busy SHALL be 1 in DATA and XFER.

Reset
REQ-028 While rst=1 at a clock edge: FSM to IDLE, counter 0, staging, shadow and active registers all 0, so cmp_en=00, all colors/vertices 0, and busy=0.
REQ-029 rst asserted mid-command SHALL discard the command; the first byte accepted after reset is decoded as a command.

Verification
REQ-030 Reset then SET_EN 0xC3 with no frame_start -> cmp_en stays 00; pulse frame_start -> cmp_en=11 on the next cycle.
REQ-031 LOAD_POLY A (0x40) with bytes 0x30,0x0A,0x05,0x50,0x05,0x2D,0x30, then frame_start -> poly_color[5:0]=0x30, v0_x[6:0]=0x0A, v2_y[5:0]=0x30, and B fields unchanged at 0.
REQ-032 LOAD_POLY B (0x41) with in_valid toggling every other cycle -> in_ready=0 exactly one cycle after the 7th byte, and after frame_start the B fields hold the loaded values in the upper bits.
REQ-033 SET_BG 0x80,0x2A with the last data byte and frame_start in the same cycle -> background_color stays at its old value, then becomes 0x2A after the next frame_start.
REQ-034 rst pulsed after the 3rd data byte of a LOAD_POLY, then SET_EN 0xC1 and frame_start -> cmp_en=01 and all vertex outputs 0.
REQ-035 Bytes 0xFF,0x3F as a SET_BG data byte -> background_color=0x3F, upper bits discarded.

Source files
------------

// File: rtl/tt_um_emern_poly_loader.sv
// Byte-stream loader for two triangle polygons, background colour and enables.
// Commands stage into shadow registers; everything goes live together on frame_start.
module tt_um_emern_poly_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        frame_start,
    output logic [1:0]  cmp_en,
    output logic [5:0]  background_color,
    output logic [11:0] poly_color,
    output logic [13:0] v0_x,
    output logic [13:0] v1_x,
    output logic [13:0] v2_x,
    output logic [11:0] v0_y,
    output logic [11:0] v1_y,
    output logic [11:0] v2_y,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StData, StXfer} state_e;

    localparam logic [1:0] TgtA  = 2'd0;
    localparam logic [1:0] TgtB  = 2'd1;
    localparam logic [1:0] TgtBg = 2'd2;

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  tgt_q, tgt_d;
    logic [7:0]  stage_q [7];

    logic        accept, stage_we, set_en_we, commit;

    logic [1:0]  sh_en_q;
    logic [5:0]  sh_bg_q;
    logic [11:0] sh_col_q, sh_v0y_q, sh_v1y_q, sh_v2y_q;
    logic [13:0] sh_v0x_q, sh_v1x_q, sh_v2x_q;

    always_comb begin
        in_ready  = !rst && (state_q != StXfer);
        busy      = (state_q != StIdle);
        accept    = in_valid && in_ready;
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        tgt_d     = tgt_q;
        stage_we  = 1'b0;
        set_en_we = 1'b0;
        commit    = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (in_data[7:6])
                        2'b01: begin
                            state_d = StData;
                            cnt_d   = 3'd7;
                            idx_d   = 3'd0;
                            tgt_d   = in_data[0] ? TgtB : TgtA;
                        end
                        2'b10: begin
                            state_d = StData;
                            cnt_d   = 3'd1;
                            idx_d   = 3'd0;
                            tgt_d   = TgtBg;
                        end
                        2'b11:   set_en_we = 1'b1;
                        default: ;
                    endcase
                end
            end
            StData: begin
                if (accept) begin
                    stage_we = 1'b1;
                    cnt_d    = cnt_q - 3'd1;
                    idx_d    = idx_q + 3'd1;
                    if (cnt_q == 3'd1) state_d = StXfer;
                end
            end
            StXfer: begin
                commit  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            idx_q   <= '0;
            tgt_q   <= '0;
            for (int i = 0; i < 7; i++) stage_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tgt_q   <= tgt_d;
            if (stage_we) stage_q[idx_q] <= in_data;
        end
    end

    // Shadow set: A fields live in the low halves, B fields in the high halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_en_q  <= '0;
            sh_bg_q  <= '0;
            sh_col_q <= '0;
            sh_v0x_q <= '0;
            sh_v1x_q <= '0;
            sh_v2x_q <= '0;
            sh_v0y_q <= '0;
            sh_v1y_q <= '0;
            sh_v2y_q <= '0;
        end else begin
            if (set_en_we) sh_en_q <= in_data[1:0];
            if (commit) begin
                if (tgt_q == TgtBg) begin
                    sh_bg_q <= stage_q[0][5:0];
                end else if (tgt_q == TgtA) begin
                    sh_col_q[5:0] <= stage_q[0][5:0];
                    sh_v0x_q[6:0] <= stage_q[1][6:0];
                    sh_v0y_q[5:0] <= stage_q[2][5:0];
                    sh_v1x_q[6:0] <= stage_q[3][6:0];
                    sh_v1y_q[5:0] <= stage_q[4][5:0];
                    sh_v2x_q[6:0] <= stage_q[5][6:0];
                    sh_v2y_q[5:0] <= stage_q[6][5:0];
                end else begin
                    sh_col_q[11:6] <= stage_q[0][5:0];
                    sh_v0x_q[13:7] <= stage_q[1][6:0];
                    sh_v0y_q[11:6] <= stage_q[2][5:0];
                    sh_v1x_q[13:7] <= stage_q[3][6:0];
                    sh_v1y_q[11:6] <= stage_q[4][5:0];
                    sh_v2x_q[13:7] <= stage_q[5][6:0];
                    sh_v2y_q[11:6] <= stage_q[6][5:0];
                end
            end
        end
    end

    // Active copy samples the shadow before any same-cycle write lands.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_en           <= '0;
            background_color <= '0;
            poly_color       <= '0;
            v0_x             <= '0;
            v1_x             <= '0;
            v2_x             <= '0;
            v0_y             <= '0;
            v1_y             <= '0;
            v2_y             <= '0;
        end else if (frame_start) begin
            cmp_en           <= sh_en_q;
            background_color <= sh_bg_q;
            poly_color       <= sh_col_q;
            v0_x             <= sh_v0x_q;
            v1_x             <= sh_v1x_q;
            v2_x             <= sh_v2x_q;
            v0_y             <= sh_v0y_q;
            v1_y             <= sh_v1y_q;
            v2_y             <= sh_v2y_q;
        end
    end

    logic unused_stage_bits;
    assign unused_stage_bits = ^{stage_q[0][7:6], stage_q[1][7], stage_q[2][7:6],
                                 stage_q[3][7], stage_q[4][7:6], stage_q[5][7],
                                 stage_q[6][7:6]};

endmodule
